ifu: RTL and testbench
======================

# ifu

Instruction fetch unit: the front end that supplies the integer execution unit with `instr`, `curr_pc` and a valid qualifier, honouring the same `stall` the execution pipeline uses. Holds the program counter, issues word fetches over a single-outstanding request/acknowledge instruction-memory port and buffers one returned word when the pipeline is stalled. Accepts redirects (`jump`) from execute and discards any fetch that is in flight at the time.

## Interface
- `XLEN`, 32, address and PC width
- `RESET_VECTOR`, 0, first fetch address after reset; bits [1:0] must be 0

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  pipeline stall; output held while high
- `jump`  in  1  redirect request, single-cycle pulse
- `jump_addr`  in  XLEN  redirect target; bits [1:0] ignored, treated as 0
- `imem_req`  out  1  fetch request
- `imem_addr`  out  XLEN  fetch address, word aligned
- `imem_ack`  in  1  response strobe; `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched word
- `instr`  out  [31:2]  instruction bits 31..2 to decode
- `curr_pc`  out  XLEN  address of `instr`
- `instr_valid`  out  1  `instr`/`curr_pc` hold a live instruction

## Operation
- Registers: `pc` (next fetch address), output register (`instr`, `curr_pc`, `instr_valid`), one-entry skid buffer (word + PC + valid), state.
- Bus rule: once `imem_req` is high, `imem_req` and `imem_addr` stay constant until the cycle `imem_ack` is sampled high. One request outstanding at most. `imem_ack` may arrive in the first request cycle. `imem_ack` without `imem_req` is ignored.
- Consumption: the output is consumed on any cycle with `instr_valid && !stall`.
- States:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`. On ack:
    - Word goes to the output register when the output is empty or being consumed.
    - Otherwise the word goes to the skid buffer and the state moves to HOLD.
    - `pc` += 4 in either case.
  - HOLD: `imem_req`=0. When the output is consumed, the skid buffer moves to the output register, the skid is cleared, and the state returns to FETCH.
  - FLUSH: `imem_req`=1 with the old address until ack. The returned word is discarded. Then go to FETCH with `pc` already equal to the redirect target.
- Redirect (`jump`=1), from any state:
  - `instr_valid` and skid valid clear next cycle.
  - `pc` ← `jump_addr & ~3`.
  - Next state:
    - FLUSH if a request is outstanding and not acked this cycle.
    - Otherwise FETCH, including when ack coincides with `jump`; that ack's word is dropped.
  - `jump` has priority over `stall` and ack.
- When the output is empty and a word is neither arriving nor in the skid, `instr_valid` goes to 0 next cycle. When valid and unconsumed, the output is held bit-exact.
- PC arithmetic is modulo 2^XLEN; `0xFFFFFFFC`+4 wraps to 0 with no flag.

## Timing
- Reset values: `instr_valid`=0, `instr`=0, `curr_pc`=`RESET_VECTOR`, `imem_req`=0, `imem_addr`=`RESET_VECTOR`, skid empty, state FETCH, `pc`=`RESET_VECTOR`.
- `imem_req` rises in the first cycle after `rst` deasserts.
- Latency: ack in cycle N → `instr_valid`/`instr` updated at the N+1 edge.
- With a zero-wait memory (ack in the request cycle) and no stall, throughput is 1 instruction/cycle.
- Redirect: `jump` in cycle N, no fetch outstanding → `imem_addr`=target in N+1; the earliest target instruction is valid in N+2.
- Reset asserted mid-request: the request is abandoned immediately (asynchronous). The memory model must drop it.
- `imem_req`, `imem_addr` and all outputs are registered or decoded from state only, with no combinational path from `imem_ack`.

## Test plan
- Reset then zero-wait memory returning word = address, no stall → `imem_addr` 0,4,8,…; `curr_pc` 0,4,8 on consecutive cycles starting 1 cycle after the first ack; `instr` = address>>2 bits.
- 3-cycle-latency memory → `imem_addr` stable across wait cycles; `instr_valid` pulses once per 3 cycles with the correct PC.
- `stall` high for 4 cycles with an ack landing mid-stall → output held unchanged, skid fills, `imem_req`=0 in HOLD. After release, the skid word appears the next cycle with no loss or duplication.
- `jump` to 0x100 while a fetch of 0x8 is outstanding → `imem_addr` stays 0x8 until ack, that word never becomes valid, then 0x100 is fetched; `jump_addr`=0x103 also fetches 0x100.
- `jump` in the same cycle as ack, and `jump` with `stall`=1 and full skid → both dropped, `instr_valid`=0 next cycle, next `curr_pc`=target.
- `RESET_VECTOR`=0xFFFFFFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0; async `rst` pulse mid-wait clears `instr_valid` and `imem_req` within the same cycle.

Source files
------------

// File: rtl/ifu_if.sv
// Instruction-memory port between the fetch unit (master) and memory (slave).
// Single outstanding request; req/addr hold steady until ack is sampled.
interface ifu_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: PC, single-outstanding imem fetch, one-entry skid
// buffer behind a stallable output register, and redirect with flush.
//
// state | meaning
// FETCH | request pc (req rises one cycle after reset)
// HOLD  | output stalled and skid full; no request
// FLUSH | redirected while a fetch is in flight; wait for and drop its ack
module ifu #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_addr,
  ifu_if.master           bus,
  output logic [31:2]     instr,
  output logic [XLEN-1:0] curr_pc,
  output logic            instr_valid
);

  typedef enum logic [1:0] {FETCH, HOLD, FLUSH} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] skid_pc;
  logic [31:2]     skid_word;
  logic            skid_valid;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;
  logic            consume;
  logic            ack;
  logic [1:0]      unused_lsbs;

  assign target      = {jump_addr[XLEN-1:2], 2'b00};
  assign pc_inc      = pc + XLEN'(4);
  assign consume     = instr_valid && !stall;
  assign ack         = bus.imem_req && bus.imem_ack;
  assign unused_lsbs = jump_addr[1:0] ^ bus.imem_rdata[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_VECTOR;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_VECTOR;
      instr         <= '0;
      curr_pc       <= RESET_VECTOR;
      instr_valid   <= 1'b0;
      skid_word     <= '0;
      skid_pc       <= RESET_VECTOR;
      skid_valid    <= 1'b0;
    end else if (jump) begin
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
      pc          <= target;
      // An unacked request must finish on the bus before the target goes out.
      if (bus.imem_req && !bus.imem_ack) begin
        state <= FLUSH;
      end else begin
        state         <= FETCH;
        bus.imem_req  <= 1'b1;
        bus.imem_addr <= target;
      end
    end else begin
      case (state)
        FETCH: begin
          if (ack) begin
            pc            <= pc_inc;
            bus.imem_addr <= pc_inc;
            if (!instr_valid || !stall) begin
              instr       <= bus.imem_rdata[31:2];
              curr_pc     <= pc;
              instr_valid <= 1'b1;
            end else begin
              skid_word    <= bus.imem_rdata[31:2];
              skid_pc      <= pc;
              skid_valid   <= 1'b1;
              bus.imem_req <= 1'b0;
              state        <= HOLD;
            end
          end else begin
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
            if (consume) instr_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (consume && skid_valid) begin
            instr         <= skid_word;
            curr_pc       <= skid_pc;
            skid_valid    <= 1'b0;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
            state         <= FETCH;
          end
        end
        FLUSH: begin
          if (consume) instr_valid <= 1'b0;
          if (bus.imem_ack) begin
            bus.imem_addr <= pc;
            state         <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: queue-based reference model of fetch/skid/redirect plus
// directed literal checks, a randomized-latency memory and random stall/jump.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = '0;
  logic [31:2] instr;
  logic [31:0] curr_pc;
  logic        instr_valid;

  logic        stall2 = 1'b0;
  logic        jump2 = 1'b0;
  logic [31:0] jump_addr2 = '0;
  logic [31:2] instr2;
  logic [31:0] curr_pc2;
  logic        instr_valid2;

  int vectors = 0;
  int errors  = 0;

  int          lat_mode = 0;
  int          lat = -1;
  logic [31:0] salt = '0;
  bit          spurious = 1'b0;

  ifu_if #(.XLEN(32)) bus ();
  ifu_if #(.XLEN(32)) bus2 ();

  ifu #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_addr(jump_addr),
    .bus(bus), .instr(instr), .curr_pc(curr_pc), .instr_valid(instr_valid)
  );

  ifu #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .stall(stall2), .jump(jump2), .jump_addr(jump_addr2),
    .bus(bus2), .instr(instr2), .curr_pc(curr_pc2), .instr_valid(instr_valid2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output register + skid seen as one FIFO of depth 2.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        oq[$];
  logic        m_req = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_pc = '0;
  bit          m_drop = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      oq.delete();
      m_req = 1'b0; m_addr = '0; m_pc = '0; m_drop = 1'b0;
    end else begin
      automatic bit took = m_req && bus.imem_ack;
      if (jump) begin
        oq.delete();
        m_pc = jump_addr & ~32'h3;
        if (m_req && !bus.imem_ack) m_drop = 1'b1;
        else begin
          m_drop = 1'b0; m_req = 1'b1; m_addr = m_pc;
        end
      end else begin
        if (oq.size() > 0 && !stall) void'(oq.pop_front());
        if (took) begin
          if (!m_drop) begin
            oq.push_back('{pc: m_addr, word: bus.imem_rdata});
            m_pc = m_pc + 32'd4;
          end
          m_drop = 1'b0;
        end
        if (took || !m_req) begin
          m_req  = (oq.size() < 2);
          m_addr = m_pc;
        end
      end
    end
  end

  // Per-cycle compare against the model, then memory responses for both DUTs.
  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    bus2.imem_ack = 1'b0; bus2.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("model_req", bus.imem_req, m_req);
        if (m_req) chk("model_addr", bus.imem_addr, m_addr);
        chk("model_valid", instr_valid, oq.size() > 0);
        if (oq.size() > 0) begin
          chk("model_instr", instr, oq[0].word[31:2]);
          chk("model_pc", curr_pc, oq[0].pc);
        end
      end
      if (bus.imem_req) begin
        if (lat < 0) lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        if (lat == 0) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = bus.imem_addr ^ salt;
          lat = -1;
        end else begin
          bus.imem_ack = 1'b0;
          lat--;
        end
      end else begin
        lat = -1;
        bus.imem_ack = spurious && ($urandom_range(0, 3) == 0);
        bus.imem_rdata = $urandom;
      end
      bus2.imem_ack = bus2.imem_req;
      bus2.imem_rdata = bus2.imem_addr;
    end
  end

  initial begin
    automatic logic [31:0] p0;
    automatic logic [31:0] a;
    automatic bit found;
    automatic int pulses;

    #1 rst = 1'b1;
    #1;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc", curr_pc, 32'h0);
    chk("rst_instr", instr, 30'h0);
    chk("rst_addr2", bus2.imem_addr, 32'hFFFF_FFF8);
    chk("rst_pc2", curr_pc2, 32'hFFFF_FFF8);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Zero-wait memory, word = address.
    @(negedge clk);
    chk("zw_req", bus.imem_req, 1'b1);
    chk("zw_addr0", bus.imem_addr, 32'h0);
    chk("zw_addr2_0", bus2.imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("zw_addr4", bus.imem_addr, 32'h4);
    chk("zw_valid0", instr_valid, 1'b1);
    chk("zw_pc0", curr_pc, 32'h0);
    chk("zw_addr2_1", bus2.imem_addr, 32'hFFFF_FFFC);
    chk("zw_pc2_0", curr_pc2, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("zw_pc4", curr_pc, 32'h4);
    chk("zw_instr1", instr, 30'h1);
    chk("zw_addr2_wrap", bus2.imem_addr, 32'h0);
    chk("zw_pc2_1", curr_pc2, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("zw_pc8", curr_pc, 32'h8);
    chk("zw_instr2", instr, 30'h2);
    chk("zw_pc2_wrap", curr_pc2, 32'h0);

    // Three-cycle latency: one valid pulse every third cycle.
    lat_mode = 2;
    repeat (6) @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (instr_valid) pulses++;
    end
    chk("lat3_pulses", 64'(pulses), 64'd10);

    // Stall for four cycles; ack lands while stalled and fills the skid.
    lat_mode = 0;
    repeat (4) @(negedge clk);
    p0 = curr_pc;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_req_low", bus.imem_req, 1'b0);
      chk("stall_held_pc", curr_pc, p0);
      chk("stall_held_valid", instr_valid, 1'b1);
      if (i == 3) stall = 1'b0;
    end
    @(negedge clk);
    chk("skid_out_pc", curr_pc, p0 + 32'd4);
    @(negedge clk);
    chk("after_skid_pc", curr_pc, p0 + 32'd8);

    // Jump coinciding with an ack.
    @(negedge clk);
    #2;
    chk("jack_pre", {bus.imem_req, bus.imem_ack}, 2'b11);
    jump = 1'b1; jump_addr = 32'h100;
    @(negedge clk);
    jump = 1'b0;
    chk("jack_valid0", instr_valid, 1'b0);
    chk("jack_addr", bus.imem_addr, 32'h100);
    @(negedge clk);
    chk("jack_valid1", instr_valid, 1'b1);
    chk("jack_pc", curr_pc, 32'h100);

    // Jump while a fetch is outstanding; unaligned target.
    lat_mode = 3;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      #2;
      if (bus.imem_req && !bus.imem_ack) found = 1'b1;
    end
    chk("flush_pre_found", found, 1'b1);
    a = bus.imem_addr;
    jump = 1'b1; jump_addr = 32'h103;
    @(negedge clk);
    jump = 1'b0;
    chk("flush_addr_held", bus.imem_addr, a);
    chk("flush_req_held", bus.imem_req, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    chk("flush_timeout", found, 1'b1);
    chk("flush_target_pc", curr_pc, 32'h100);

    // Jump while stalled with the skid full.
    lat_mode = 0;
    repeat (3) @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_req", bus.imem_req, 1'b0);
    jump = 1'b1; jump_addr = 32'h40;
    @(negedge clk);
    jump = 1'b0; stall = 1'b0;
    chk("hjump_valid0", instr_valid, 1'b0);
    chk("hjump_addr", bus.imem_addr, 32'h40);
    @(negedge clk);
    chk("hjump_pc", curr_pc, 32'h40);

    // Randomized traffic.
    salt = $urandom;
    spurious = 1'b1;
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 9) < 3);
      jump  = !jump && ($urandom_range(0, 24) == 0);
      jump_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
    end
    @(negedge clk);
    stall = 1'b0; jump = 1'b0;

    // Asynchronous reset while waiting on an ack.
    lat_mode = 3;
    spurious = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      #2;
      if (bus.imem_req && !bus.imem_ack) found = 1'b1;
    end
    chk("arst_pre_found", found, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_req", bus.imem_req, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
